// File: rtl/axi_sram_slave.sv
// axi_sram_slave: single-beat AXI3 slave over a word SRAM; AXI_SLV_DELAY_EN adds LFSR-driven ready/R stalls.
// Latency: AR handshake -> rvalid after the next edge, write commit -> bvalid the following cycle.
// Backpressure: arready drops while the read queue is full; R and B outputs hold until accepted.

module axi_sram_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] ram [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop_dat = ram[rptr[AW-1:0]];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push) ram[wptr[AW-1:0]] <= push_dat;
  end
endmodule

module axi_sram_slave #(
  parameter int          MEM_AW   = 12,
  parameter int          RQ_DEPTH = 4,
  parameter logic [15:0] DLY_SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);
  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_GOT_AW = 2'd1;
  localparam logic [1:0] W_GOT_W  = 2'd2;
  localparam logic [1:0] W_RESP   = 2'd3;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] dat;
    logic        err;
  } rq_t;

  logic [31:0] mem [2**MEM_AW];

  logic ready_en;
  logic stall;
  logic unused_ok;

  assign unused_ok = ^{arsize, araddr[31:MEM_AW+2], araddr[1:0],
                       awaddr[31:MEM_AW+2], awaddr[1:0], DLY_SEED};

`ifdef AXI_SLV_DELAY_EN
  logic [15:0] lfsr;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) lfsr <= DLY_SEED;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // Read path: data is captured into the queue at the AR handshake.
  logic              ar_hs;
  logic              ar_err;
  logic [MEM_AW-1:0] ar_idx;
  logic              rq_empty;
  logic              rq_full;
  logic              r_load;
  rq_t               rq_in;
  rq_t               rq_out;

  assign arready = ready_en & ~rq_full & ~stall;
  assign ar_hs   = arvalid & arready;
  assign ar_err  = (arlen != 8'd0);
  assign ar_idx  = araddr[MEM_AW+1:2];
  assign r_load  = ~rq_empty & (~rvalid | rready) & ~stall;
  assign rlast   = 1'b1;

  always_comb begin
    rq_in     = '0;
    rq_in.id  = arid;
    rq_in.dat = ar_err ? 32'd0 : mem[ar_idx];
    rq_in.err = ar_err;
  end

  axi_sram_fifo #(.W($bits(rq_t)), .DEPTH(RQ_DEPTH)) u_rq (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .push     (ar_hs),
    .push_dat (rq_in),
    .pop      (r_load),
    .pop_dat  (rq_out),
    .empty    (rq_empty),
    .full     (rq_full)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid <= 1'b0;
      rid    <= 4'd0;
      rdata  <= 32'd0;
      rresp  <= 2'b00;
    end else if (r_load) begin
      rvalid <= 1'b1;
      rid    <= rq_out.id;
      rdata  <= rq_out.dat;
      rresp  <= rq_out.err ? 2'b10 : 2'b00;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

  // Write path: AW and W may arrive in either order; one half is held until the other shows up.
  logic [1:0]        w_state;
  logic              aw_hs;
  logic              w_hs;
  logic [3:0]        aw_id_q;
  logic [MEM_AW-1:0] aw_idx_q;
  logic              aw_err_q;
  logic [31:0]       w_dat_q;
  logic [3:0]        w_strb_q;
  logic              w_last_q;
  logic              cm_en;
  logic [3:0]        cm_id;
  logic [MEM_AW-1:0] cm_idx;
  logic              cm_bad;
  logic [31:0]       cm_dat;
  logic [3:0]        cm_strb;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign bvalid = (w_state == W_RESP);

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = ready_en & ~stall;
        wready  = ready_en & ~stall;
      end
      W_GOT_AW: wready  = ~stall;
      W_GOT_W:  awready = ~stall;
      default: ;
    endcase
  end

  always_comb begin
    cm_en   = 1'b0;
    cm_id   = awid;
    cm_idx  = awaddr[MEM_AW+1:2];
    cm_bad  = (awlen != 8'd0) | ~wlast;
    cm_dat  = wdata;
    cm_strb = wstrb;
    case (w_state)
      W_IDLE: cm_en = aw_hs & w_hs;
      W_GOT_AW: begin
        cm_en  = w_hs;
        cm_id  = aw_id_q;
        cm_idx = aw_idx_q;
        cm_bad = aw_err_q | ~wlast;
      end
      W_GOT_W: begin
        cm_en   = aw_hs;
        cm_dat  = w_dat_q;
        cm_strb = w_strb_q;
        cm_bad  = (awlen != 8'd0) | ~w_last_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      aw_id_q  <= 4'd0;
      aw_idx_q <= '0;
      aw_err_q <= 1'b0;
      w_dat_q  <= 32'd0;
      w_strb_q <= 4'd0;
      w_last_q <= 1'b0;
      bid      <= 4'd0;
      bresp    <= 2'b00;
    end else begin
      if (aw_hs) begin
        aw_id_q  <= awid;
        aw_idx_q <= awaddr[MEM_AW+1:2];
        aw_err_q <= (awlen != 8'd0);
      end
      if (w_hs) begin
        w_dat_q  <= wdata;
        w_strb_q <= wstrb;
        w_last_q <= wlast;
      end
      if (cm_en) begin
        bid   <= cm_id;
        bresp <= cm_bad ? 2'b10 : 2'b00;
      end
      case (w_state)
        W_IDLE: begin
          if (aw_hs & w_hs) w_state <= W_RESP;
          else if (aw_hs)   w_state <= W_GOT_AW;
          else if (w_hs)    w_state <= W_GOT_W;
        end
        W_GOT_AW: if (w_hs)   w_state <= W_RESP;
        W_GOT_W:  if (aw_hs)  w_state <= W_RESP;
        default:  if (bready) w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (cm_en && !cm_bad) begin
      for (int k = 0; k < 4; k++) begin
        if (cm_strb[k]) mem[cm_idx][8*k +: 8] <= cm_dat[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: write/read-back, strobes, split AW/W, read backpressure, bad bursts, reset.
module tb_axi_sram_slave;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int tests = 0;
  int fails = 0;

  axi_sram_slave dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [31:0] dat, input logic [3:0] strb, input logic last,
                    input logic [1:0] exp_resp, input string tag);
    awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
    wdata = dat; wstrb = strb; wlast = last; wvalid = 1'b1;
    chk({tag, ".rdy"}, {30'd0, awready, wready}, 32'd3);
    step();
    awvalid = 1'b0; wvalid = 1'b0; awlen = 8'd0; wlast = 1'b1;
    chk({tag, ".bvalid"}, bvalid, 1);
    chk({tag, ".bid"}, bid, id);
    chk({tag, ".bresp"}, bresp, exp_resp);
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk({tag, ".bdone"}, bvalid, 0);
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [31:0] exp_dat, input logic [1:0] exp_resp, input string tag);
    int n;
    arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 16) begin step(); n++; end
    chk({tag, ".arready"}, arready, 1);
    step();
    arvalid = 1'b0; arlen = 8'd0;
    n = 0;
    while (!rvalid && n < 16) begin step(); n++; end
    chk({tag, ".rvalid"}, rvalid, 1);
    chk({tag, ".rid"}, rid, id);
    chk({tag, ".rdata"}, rdata, exp_dat);
    chk({tag, ".rresp"}, rresp, exp_resp);
    chk({tag, ".rlast"}, rlast, 1);
    rready = 1'b1;
    step();
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wlast = 1; wvalid = 0; bready = 0;

    // Reset values
    #22;
    chk("rst.readies", {29'd0, arready, awready, wready}, 0);
    chk("rst.valids", {30'd0, rvalid, bvalid}, 0);
    chk("rst.rlast", rlast, 1);
    chk("rst.rdata", rdata, 0);
    chk("rst.ids", {24'd0, rid, bid}, 0);
    chk("rst.resps", {28'd0, rresp, bresp}, 0);
    @(posedge aclk);
    #1 aresetn = 1'b1;
    chk("rel.arready0", arready, 0);
    step();
    chk("rel.readies1", {29'd0, arready, awready, wready}, 3'b111);

    // Same-cycle AW+W, then read-back with exact latency
    wr(4'd1, 32'h100, 8'd0, 32'hDEADBEEF, 4'hF, 1'b1, 2'b00, "wr1");
    arid = 4'd0; araddr = 32'h100; arvalid = 1'b1;
    chk("lat.arready", arready, 1);
    step();
    arvalid = 1'b0;
    chk("lat.edge1", rvalid, 0);
    step();
    chk("lat.edge2", rvalid, 1);
    chk("lat.rdata", rdata, 32'hDEADBEEF);
    chk("lat.rid", rid, 0);
    chk("lat.rlast", rlast, 1);
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("lat.drain", rvalid, 0);

    // Byte strobe
    wr(4'd2, 32'h100, 8'd0, 32'h0000AA00, 4'b0010, 1'b1, 2'b00, "wstrb");
    rd(4'd3, 32'h100, 8'd0, 32'hDEADAAEF, 2'b00, "rdstrb");

    // W three cycles ahead of AW, then held B
    wdata = 32'h12345678; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("split.wready", wready, 0);
    chk("split.awready", awready, 1);
    step();
    step();
    chk("split.nob", bvalid, 0);
    awid = 4'd3; awaddr = 32'h200; awlen = 8'd0; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("split.bvalid", bvalid, 1);
      chk("split.bid", bid, 3);
      chk("split.bresp", bresp, 0);
      chk("split.rdys", {30'd0, awready, wready}, 0);
      step();
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("split.bdone", bvalid, 0);
    rd(4'd4, 32'h200, 8'd0, 32'h12345678, 2'b00, "rdsplit");

    // Read backpressure: 5 accepted, 6th stalls until a beat drains
    araddr = 32'h100; arlen = 8'd0; arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      arid = 4'(i);
      chk("bp.accept", arready, 1);
      step();
    end
    arid = 4'd5;
    chk("bp.full", arready, 0);
    step();
    chk("bp.full2", arready, 0);
    chk("bp.hold_rid", rid, 0);
    chk("bp.hold_rvalid", rvalid, 1);
    rready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("bp.rvalid", rvalid, 1);
      chk("bp.rid", rid, 32'(i));
      chk("bp.rdata", rdata, 32'hDEADAAEF);
      if (i == 1) chk("bp.reopen", arready, 1);
      step();
      if (i == 1) arvalid = 1'b0;
    end
    chk("bp.empty", rvalid, 0);
    rready = 1'b0;

    // Illegal bursts and wlast=0
    rd(4'd7, 32'h100, 8'd3, 32'h0, 2'b10, "badar");
    wr(4'd4, 32'h100, 8'd1, 32'hFFFFFFFF, 4'hF, 1'b1, 2'b10, "badaw");
    wr(4'd5, 32'h100, 8'd0, 32'hFFFFFFFF, 4'hF, 1'b0, 2'b10, "badwlast");
    rd(4'd6, 32'h100, 8'd0, 32'hDEADAAEF, 2'b00, "rdbad");
    rd(4'd9, 32'h4100, 8'd0, 32'hDEADAAEF, 2'b00, "alias");

    // Reset with two reads outstanding
    araddr = 32'h100; arid = 4'd8; arvalid = 1'b1;
    step();
    arid = 4'd9;
    step();
    arvalid = 1'b0;
    chk("mid.pending", rvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    chk("mid.rvalid", rvalid, 0);
    chk("mid.arready", arready, 0);
    chk("mid.rdata", rdata, 0);
    step();
    aresetn = 1'b1;
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid.nostale", rvalid, 0);
    end
    rready = 1'b0;
    rd(4'd10, 32'h100, 8'd0, 32'hDEADAAEF, 2'b00, "postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- Single-beat AXI3 slave backed by a word-addressed SRAM array.
- Sits directly downstream of the CPU's AXI bridge and consumes its AR/R/AW/W/B traffic.
- Serves as the memory endpoint for bridge-level and core-level simulation.
- Supports in-order outstanding reads and one write in flight.

Parameters:
- MEM_AW, 12, log2 of memory depth in 32-bit words; word index = addr[MEM_AW+1:2].
- RQ_DEPTH, 4, read-queue entries; must be a power of two, at least 2.
- DLY_SEED, 16'hACE1, LFSR seed; used only with AXI_SLV_DELAY_EN.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- arid  in  4  read ID
- araddr  in  32  read address
- arlen  in  8  burst length; only 0 is legal
- arsize  in  3  ignored
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rid  out  4  response ID
- rdata  out  32  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rlast  out  1  last beat
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awid  in  4  write ID
- awaddr  in  32  write address
- awlen  in  8  burst length; only 0 is legal
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wlast  in  1  last beat
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bid  out  4  response ID
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Clock and reset:
  - One clock, aclk.
  - aresetn is asynchronous and active-low.
  - While aresetn is low: all valid/ready outputs are 0; rid, rdata, rresp, bid and bresp are 0; rlast is 1.
  - A ready_en flop goes to 1 on the first edge after release, so ready outputs are first high in the second cycle after release.
  - Memory contents are never cleared by reset.
  - Reset mid-operation discards the queue, the R register and any held AW/W/B. No response is ever issued for a discarded transaction.
- Read path:
  - arready = ready_en & ~queue_full.
  - On an AR handshake, push {arid, mem[idx], err} into the queue, where err = (arlen != 0).
  - The data is sampled at the handshake edge. A write committing on that same edge is NOT visible.
  - When err is set: rdata = 0 and rresp = 2'b10.
  - R output register loads the queue head when (~rvalid | rready) and the queue is non-empty. rvalid is set by the load and cleared on a handshake with nothing left to load.
  - Minimum latency: AR handshake at edge N gives rvalid high after edge N+1.
  - Full throughput: one beat per cycle.
  - Responses are returned in order. rlast = 1 on every beat.
  - rid, rdata and rresp are held stable while rvalid & ~rready.
  - Maximum outstanding reads = RQ_DEPTH + 1.
  - Push and pop on the same edge while the queue is full: the pop frees a slot, but arready is still computed from the pre-edge full flag.
- Write path, FSM states:
  - W_IDLE: awready = wready = ready_en.
    - AW only -> W_GOT_AW.
    - W only -> W_GOT_W.
    - Both in the same cycle -> commit, then W_RESP.
  - W_GOT_AW: awready = 0, wready = 1. W handshake -> commit, then W_RESP.
  - W_GOT_W: wready = 0, awready = 1. AW handshake -> commit, then W_RESP.
  - W_RESP: both readies 0, bvalid = 1. On bvalid & bready -> W_IDLE.
- Commit:
  - Written bytes: mem[idx] byte k <= wdata byte k, for each set wstrb[k].
  - bid = held awid.
  - bresp = 2'b10 and no memory write when awlen != 0 or wlast == 0; otherwise bresp = 2'b00.
  - bvalid is high the cycle after the commit edge.
- Addresses with bits above MEM_AW+1 alias onto the array; there is no decode error.

Optional Feature:
- Macro: AXI_SLV_DELAY_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) resets to DLY_SEED and advances every cycle.
  - When lfsr[0] = 1, that cycle: arready, awready and wready are forced to 0, and the R register does not load.
  - Held outputs stay stable during a stall. Ordering and results are unchanged.
- Undefined: no stalls; latencies are as stated above.

Test Plan:
- Write path then read-back:
  - AW (awid 1, addr 0x100) and W (0xDEADBEEF, wstrb 4'hF, wlast 1) in the same cycle -> bvalid next cycle, bid 1, bresp 00.
  - Then AR (arid 0, addr 0x100) -> rvalid two edges after the handshake, rdata 0xDEADBEEF, rlast 1.
- Byte-strobe write: wstrb 4'b0010, wdata 0x0000AA00 to 0x100 -> a later read returns 0xDEADAAEF.
- Independent W and AW: W accepted 3 cycles before AW -> wready low after the W handshake. Commit occurs on the AW edge; bvalid next cycle. With bready held 0 for 4 cycles -> bvalid, bid and bresp stable, awready and wready 0.
- Read backpressure: rready 0, 6 back-to-back ARs with ids 0..5 and RQ_DEPTH=4 -> arready low after 5 are accepted. Then rready 1 -> 5 beats with rid 0..4 in order. Then id 5 is accepted and returned.
- Illegal bursts:
  - arlen 3 -> rresp 2'b10, rdata 0.
  - awlen 1 -> bresp 2'b10, and the target word is unchanged on read-back.
- Reset mid-flight: aresetn low asynchronously mid-cycle with 2 reads outstanding -> rvalid and arready 0 immediately, no stale beats after release. Memory at 0x100 is still 0xDEADAAEF.
